// File: rtl/sdram_host_responder.sv
// sdram_host_responder: on-chip RAM stand-in for the SDRAM controller host
// port. Single-word writes and reads with fixed busy latencies, a held
// read-data handshake, and a saturating count of requests dropped while busy.
module sdram_host_responder #(
  parameter int HADDR_WIDTH = 24,
  parameter int MEM_AW      = 8,
  parameter int WR_LATENCY  = 4,
  parameter int RD_LATENCY  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HADDR_WIDTH-1:0] haddr,
  input  logic                   wr_enable,
  input  logic [15:0]            wr_data,
  input  logic                   rd_enable,
  output logic [15:0]            rd_data,
  output logic                   rd_rdy,
  input  logic                   rd_ack,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);

  localparam logic [7:0] WR_LAT = 8'(WR_LATENCY);
  localparam logic [7:0] RD_LAT = 8'(RD_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDY
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic              busy_q, busy_d;
  logic [15:0]       drop_q, drop_d;
  logic              mem_we;

  logic [15:0] mem [2**MEM_AW];

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic unused_haddr_hi;
  assign unused_haddr_hi = ^haddr[HADDR_WIDTH-1:MEM_AW];

  // Next-state, latency counting, handshake and drop-count logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rd_rdy_d  = rd_rdy_q;
    busy_d    = busy_q;
    drop_d    = drop_q;
    mem_we    = 1'b0;

    if (busy_q && (wr_enable || rd_enable) && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_enable) begin
          addr_d  = haddr[MEM_AW-1:0];
          wdata_d = wr_data;
          cnt_d   = WR_LAT;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end else if (rd_enable) begin
          addr_d  = haddr[MEM_AW-1:0];
          cnt_d   = RD_LAT;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (cnt_q == 8'd1) begin
          mem_we  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_READ: begin
        if (cnt_q == 8'd1) begin
          rd_data_d = mem[addr_q];
          rd_rdy_d  = 1'b1;
          state_d   = S_RDY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RDY: begin
        if (rd_ack) begin
          rd_rdy_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_rdy_q  <= rd_rdy_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  // Backing RAM: not cleared by reset; a reset on the final write cycle aborts it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_rdy   = rd_rdy_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sdram_host_responder.sv
// Self-checking bench for sdram_host_responder: timestamp-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_sdram_host_responder;

  localparam int WL = 4;
  localparam int RL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] haddr;
  logic        wr_enable;
  logic [15:0] wr_data;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_rdy;
  logic        rd_ack;
  logic        busy;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  sdram_host_responder #(
    .HADDR_WIDTH(24),
    .MEM_AW(8),
    .WR_LATENCY(WL),
    .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .haddr(haddr),
    .wr_enable(wr_enable),
    .wr_data(wr_data),
    .rd_enable(rd_enable),
    .rd_data(rd_data),
    .rd_rdy(rd_rdy),
    .rd_ack(rd_ack),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges are numbered; pending operations complete at a
  // scheduled edge number; RAM is a plain array with per-word known flags.
  int          cyc = 0;
  int          w_at = -1;
  int          r_at = -1;
  bit          m_rdy = 1'b0;
  bit          m_valid = 1'b0;
  logic [15:0] m_rd = '0;
  bit          m_rd_known = 1'b0;
  int          m_drop = 0;
  logic [7:0]  w_addr, r_addr;
  logic [15:0] w_dat;
  logic [15:0] mmem [256];
  bit          known [256];

  function automatic bit m_busy();
    return (w_at >= 0) || (r_at >= 0) || m_rdy;
  endfunction

  always @(posedge clk) begin
    bit bp;
    cyc++;
    if (rst) begin
      w_at = -1; r_at = -1; m_rdy = 1'b0;
      m_rd = '0; m_rd_known = 1'b1; m_drop = 0; m_valid = 1'b1;
    end else begin
      bp = m_busy();
      if (bp && (wr_enable || rd_enable) && m_drop < 65535) m_drop++;
      if (m_rdy && rd_ack) m_rdy = 1'b0;
      if (w_at == cyc) begin
        mmem[w_addr] = w_dat; known[w_addr] = 1'b1; w_at = -1;
      end
      if (r_at == cyc) begin
        m_rd = mmem[r_addr]; m_rd_known = known[r_addr]; m_rdy = 1'b1; r_at = -1;
      end
      if (!bp) begin
        if (wr_enable) begin
          w_at = cyc + WL; w_addr = haddr[7:0]; w_dat = wr_data;
        end else if (rd_enable) begin
          r_at = cyc + RL; r_addr = haddr[7:0];
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("rd_rdy", 32'(rd_rdy), 32'(m_rdy));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk); n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [15:0] d);
    haddr = a; wr_data = d; wr_enable = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input logic [23:0] a, output logic [15:0] d);
    int n = 0;
    haddr = a; rd_enable = 1'b1;
    @(negedge clk);
    rd_enable = 1'b0;
    while (!rd_rdy && n < 1000) begin
      @(negedge clk); n++;
    end
    if (!rd_rdy) chk("read_timeout", 32'(rd_rdy), 32'd1);
    d = rd_data;
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int n;
    int exp_drops;
    rst = 1'b1; haddr = '0; wr_enable = 1'b0; wr_data = '0; rd_enable = 1'b0; rd_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Default write/read with latency measurement
    haddr = 24'h000010; wr_data = 16'hA5C3; wr_enable = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++; @(negedge clk);
    end
    chk("wr_busy_cycles", 32'(n), 32'd4);
    haddr = 24'h000010; rd_enable = 1'b1;
    @(negedge clk);
    rd_enable = 1'b0;
    n = 0;
    while (!rd_rdy && n < 100) begin
      @(negedge clk); n++;
    end
    chk("rd_latency", 32'(n), 32'd6);
    chk("rd_data_a5c3", 32'(rd_data), 32'h0000A5C3);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("ack_clears_rdy", 32'(rd_rdy), 32'd0);
    chk("ack_clears_busy", 32'(busy), 32'd0);

    // Address aliasing
    do_write(24'h000105, 16'h1234);
    do_read(24'hFFFF05, d);
    chk("alias_data", 32'(d), 32'h00001234);

    // Simultaneous write and read: write wins, nothing dropped
    haddr = 24'h000030; wr_data = 16'h5555; wr_enable = 1'b1; rd_enable = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0; rd_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("simul_no_rdy", 32'(rd_rdy), 32'd0);
      @(negedge clk);
    end
    chk("simul_drop", 32'(drop_cnt), 32'd0);
    do_read(24'h000030, d);
    chk("simul_write_done", 32'(d), 32'h00005555);

    // Alternating enables for 20 cycles
    exp_drops = 0;
    for (int i = 0; i < 20; i++) begin
      wr_enable = (i % 2 == 0);
      rd_enable = (i % 2 == 1);
      haddr = 24'(32'h40 + $urandom_range(0, 3));
      wr_data = 16'($urandom);
      if (m_busy()) exp_drops++;
      @(negedge clk);
    end
    wr_enable = 1'b0; rd_enable = 1'b0; rd_ack = 1'b1;
    wait_idle();
    rd_ack = 1'b0;
    @(negedge clk);
    chk("toggle_drops", 32'(drop_cnt), 32'(exp_drops));

    // Reset on the 2nd busy cycle of a write aborts it
    do_write(24'h000020, 16'h0F0F);
    haddr = 24'h000020; wr_data = 16'hBEEF; wr_enable = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    do_read(24'h000020, d);
    chk("midrst_old_data", 32'(d), 32'h00000F0F);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      wr_enable = ($urandom_range(0, 3) == 0);
      rd_enable = ($urandom_range(0, 3) == 0);
      rd_ack    = ($urandom_range(0, 2) == 0);
      haddr     = {16'($urandom), 4'h0, 4'($urandom)};
      wr_data   = 16'($urandom);
      @(negedge clk);
    end
    wr_enable = 1'b0; rd_enable = 1'b0; rd_ack = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Saturation: park in the ready state and hammer requests
    haddr = 24'h000010; rd_enable = 1'b1;
    @(negedge clk);
    rd_enable = 1'b0;
    wr_enable = 1'b1;
    repeat (70000) @(negedge clk);
    wr_enable = 1'b0;
    @(negedge clk);
    chk("drop_saturated", 32'(drop_cnt), 32'h0000FFFF);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("sat_ack_idle", 32'(busy), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
